// File: rtl/fft_fifo_pkg.sv
// Shared sample format for the FFT datapath: the default sample width, the re/im
// field positions and a packed sample type.
package fft_fifo_pkg;

  localparam int SAMPLE_W = 32;
  localparam int HALF_W   = SAMPLE_W / 2;

  // Field positions inside a {re, im} sample word.
  localparam int RE_MSB = SAMPLE_W - 1;
  localparam int RE_LSB = HALF_W;
  localparam int IM_MSB = HALF_W - 1;
  localparam int IM_LSB = 0;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } sample_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with one write port and one registered, enabled read port.
// It has the shape a block RAM with an output register is inferred from.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset. A reset term here would stop block RAM inference,
  // and the pointers already mark which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // The output register keeps its value when no read is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/burst_data_fifo.sv
// Synchronous FIFO for complex FFT input samples. It provides ready/valid handshakes,
// occupancy status, sticky overflow/underflow flags and a frame-buffered (burst-ready) flag.
module burst_data_fifo
  import fft_fifo_pkg::*;
#(
  parameter int DATA_W       = SAMPLE_W,
  parameter int DEPTH_LOG2   = 10,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic [DATA_W-1:0]     i_data_in,
  input  logic                  i_data_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_store_valid,
  output logic [DATA_W-1:0]     o_store_data,
  output logic                  o_store_data_valid,
  input  logic [DEPTH_LOG2:0]   i_burst_len,
  output logic                  o_burst_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_acc, rd_acc;

  // All status flags come from the registered count, so acceptance this cycle never
  // depends on the other port's request in the same cycle.
  assign o_count       = count;
  assign o_full        = (count == CNT_W'(DEPTH));
  assign o_empty       = (count == '0);
  assign o_in_ready    = ~o_full;
  assign o_almost_full = (count >= CNT_W'(DEPTH - AFULL_MARGIN));
  assign o_burst_ready = (i_burst_len != '0) && (count >= i_burst_len);

  assign wr_acc = i_data_in_valid & ~o_full  & ~i_clr;
  assign rd_acc = i_store_valid   & ~o_empty & ~i_clr;

  // NOTE: state registers use non-blocking assignments only. Every flop then samples
  // the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      o_overflow         <= 1'b0;
      o_underflow        <= 1'b0;
      o_store_data_valid <= 1'b0;
    end else if (i_clr) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      o_overflow         <= 1'b0;
      o_underflow        <= 1'b0;
      o_store_data_valid <= 1'b0;
    end else begin
      // The pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo DEPTH without extra logic.
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_data_in_valid && o_full)  o_overflow  <= 1'b1;
      if (i_store_valid   && o_empty) o_underflow <= 1'b1;
      o_store_data_valid <= rd_acc;
    end
  end

  // Read and write addresses differ whenever both are accepted (that needs 0 < count < DEPTH),
  // so read-during-write behaviour of the RAM never matters.
  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_data_in),
    .re      (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (o_store_data)
  );

endmodule

// File: tb/tb_burst_data_fifo.sv
// Self-checking bench for burst_data_fifo. A queue-based reference model is compared
// with the DUT outputs after every clock edge, for directed and randomized traffic.
module tb_burst_data_fifo;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1024;
  localparam int AFULL_M    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_clr = 1'b0;
  logic [DATA_W-1:0]   i_data_in = '0;
  logic                i_data_in_valid = 1'b0;
  logic                i_store_valid = 1'b0;
  logic [DEPTH_LOG2:0] i_burst_len = '0;
  logic                o_in_ready, o_store_data_valid, o_burst_ready;
  logic                o_full, o_empty, o_almost_full, o_overflow, o_underflow;
  logic [DATA_W-1:0]   o_store_data;
  logic [DEPTH_LOG2:0] o_count;

  always #5 clk = ~clk;

  burst_data_fifo #(
    .DATA_W       (DATA_W),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .AFULL_MARGIN (AFULL_M)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_clr              (i_clr),
    .i_data_in          (i_data_in),
    .i_data_in_valid    (i_data_in_valid),
    .o_in_ready         (o_in_ready),
    .i_store_valid      (i_store_valid),
    .o_store_data       (o_store_data),
    .o_store_data_valid (o_store_data_valid),
    .i_burst_len        (i_burst_len),
    .o_burst_ready      (o_burst_ready),
    .o_count            (o_count),
    .o_full             (o_full),
    .o_empty            (o_empty),
    .o_almost_full      (o_almost_full),
    .o_overflow         (o_overflow),
    .o_underflow        (o_underflow)
  );

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid, exp_ovf, exp_udf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic compare_all();
    int n;
    n = model_q.size();
    check("count",       64'(o_count),           64'(n));
    check("full",        64'(o_full),            64'(n == DEPTH));
    check("empty",       64'(o_empty),           64'(n == 0));
    check("in_ready",    64'(o_in_ready),        64'(n != DEPTH));
    check("almost_full", 64'(o_almost_full),     64'(n >= DEPTH - AFULL_M));
    check("burst_ready", 64'(o_burst_ready),     64'((i_burst_len != 0) && (n >= int'(i_burst_len))));
    check("overflow",    64'(o_overflow),        64'(exp_ovf));
    check("underflow",   64'(o_underflow),       64'(exp_udf));
    check("data_valid",  64'(o_store_data_valid), 64'(exp_valid));
    check("store_data",  64'(o_store_data),      64'(exp_data));
  endtask

  // Apply one cycle of requests, advance the model, then check all DUT outputs after the edge.
  task automatic step(input logic wr, input logic [DATA_W-1:0] wd, input logic rd, input logic clr);
    bit was_full, was_empty;
    i_data_in_valid = wr;
    i_data_in       = wd;
    i_store_valid   = rd;
    i_clr           = clr;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (clr) begin
      model_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (wr && was_full)  exp_ovf = 1'b1;
      if (rd && was_empty) exp_udf = 1'b1;
      if (rd && !was_empty) begin
        exp_data  = model_q.pop_front();
        exp_valid = 1'b1;
      end
      if (wr && !was_full) model_q.push_back(wd);
    end
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    bit wr, rd, clr;
    int wr_pct, rd_pct;

    model_reset();
    // Reset held for several clocks with requests active
    i_data_in_valid = 1'b1;
    i_store_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    i_data_in_valid = 1'b0;
    i_store_valid   = 1'b0;
    rst_n = 1'b1;
    idle();

    // Reset asserted mid-burst discards the contents
    for (int i = 0; i < 20; i++) step(1'b1, 32'hA000_0000 + 32'(i), (i % 3) == 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("reset_count", 64'(o_count), 64'd0);
    check("reset_empty", 64'(o_empty), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Fill with a sequential pattern, then check the almost-full threshold and full
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'h0001_0000 + 32'(i), 1'b0, 1'b0);
      if (i == DEPTH - AFULL_M - 2) check("afull_below", 64'(o_almost_full), 64'd0);
      if (i == DEPTH - AFULL_M - 1) check("afull_at",    64'(o_almost_full), 64'd1);
    end
    check("full_at_depth", 64'(o_full), 64'd1);

    // A write while full sets overflow and leaves the count unchanged
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("ovf_set",   64'(o_overflow), 64'd1);
    check("ovf_count", 64'(o_count),    64'd1024);

    // Simultaneous read and write at count 1024: the read wins
    step(1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
    check("sim_1024",      64'(o_count),      64'd1023);
    check("sim_1024_data", 64'(o_store_data), 64'h0001_0000);

    // Drain the remaining entries; data is checked in order by the model
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_last", 64'(o_store_data), 64'h0001_03FF);
    idle();
    check("valid_one_cycle", 64'(o_store_data_valid), 64'd0);

    // A read while empty sets underflow and produces no valid
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_set",   64'(o_underflow),        64'd1);
    check("udf_valid", 64'(o_store_data_valid), 64'd0);

    // Simultaneous read and write at count 0: the write wins
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    check("sim_0", 64'(o_count), 64'd1);
    check("ovf_sticky", 64'(o_overflow), 64'd1);

    // Clear flushes the contents and both sticky flags
    step(1'b1, 32'h5555_0000, 1'b1, 1'b1);
    check("clr_ovf", 64'(o_overflow),  64'd0);
    check("clr_udf", 64'(o_underflow), 64'd0);

    // Simultaneous read and write at count 512
    for (int i = 0; i < 512; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0);
    check("sim_512", 64'(o_count), 64'd512);
    step(1'b0, '0, 1'b0, 1'b1);

    // Burst-ready threshold
    i_burst_len = 11'd256;
    for (int i = 0; i < 255; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    check("burst_255", 64'(o_burst_ready), 64'd0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    check("burst_256", 64'(o_burst_ready), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("burst_after_rd", 64'(o_burst_ready), 64'd0);
    i_burst_len = 11'd0;
    step(1'b1, $urandom, 1'b0, 1'b0);
    check("burst_disabled", 64'(o_burst_ready), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomized interleaved traffic with phases biased toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      if ((i / 750) % 2 == 0) begin wr_pct = 95; rd_pct = 20; end
      else                    begin wr_pct = 20; rd_pct = 95; end
      wr  = ($urandom_range(99) < wr_pct);
      rd  = ($urandom_range(99) < rd_pct);
      clr = ($urandom_range(599) == 0);
      d   = $urandom;
      if (($urandom_range(49)) == 0) i_burst_len = 11'($urandom_range(DEPTH));
      if (i == 1500) begin
        step(wr, d, rd, 1'b1);
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_empty", 64'(o_empty), 64'd1);
        step(1'b1, 32'hC0FF_EE00, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_readback", 64'(o_store_data), 64'hC0FF_EE00);
      end else begin
        step(wr, d, rd, clr);
      end
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
